// File: rtl/addn_dec.sv
// addn_dec: two-stage pipelined binary/BCD adder-ALU.
// Valid/ready handshake on input and output sides.
module addn_dec #(
   parameter int WIDTH  = 8,
   parameter int DEC_EN = 1
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             CI,
   input  logic [2:0]       op,
   input  logic             D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] O,
   output logic             CO,
   output logic             V,
   output logic             N,
   output logic             Z,
   output logic [WIDTH-1:0] CARRY
);
   localparam int NIB = WIDTH / 4;

   logic [WIDTH-1:0] b_d, lg_d, cin_d, carry_d, res_d;
   logic [WIDTH:0]   sum_d;
   logic             arith_d, sub_d, dec_d, v_d;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_res_q, s1_carry_q, s1_a_q, s1_b_q;
   logic             s1_co_q, s1_v_q, s1_ci_q, s1_dec_q, s1_sub_q;

   logic             s2_valid_q;
   logic [WIDTH-1:0] o_q, carry_q;
   logic             co_q, v_q, n_q, z_q;

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] dec_o, o_d;
   logic [4:0]       dec_s;
   logic             dec_c, co_d;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      b_d     = '0;
      lg_d    = '0;
      arith_d = 1'b1;
      sub_d   = 1'b0;
      unique case (op)
         3'b000: b_d = I1;
         3'b001: begin
            b_d   = ~I1;
            sub_d = 1'b1;
         end
         3'b010: begin
            lg_d    = I0 & I1;
            arith_d = 1'b0;
         end
         3'b011: begin
            lg_d    = I0 | I1;
            arith_d = 1'b0;
         end
         3'b100: begin
            lg_d    = I0 ^ I1;
            arith_d = 1'b0;
         end
         3'b101: begin
            lg_d    = I0;
            arith_d = 1'b0;
         end
         3'b110: b_d = '0;
         3'b111: b_d = '1;
      endcase
   end

   // Carry into each bit recovered from the sum, then ripple carry-out.
   assign sum_d   = {1'b0, I0} + {1'b0, b_d} + {{WIDTH{1'b0}}, CI};
   assign cin_d   = sum_d[WIDTH-1:0] ^ I0 ^ b_d;
   assign carry_d = (I0 & b_d) | ((I0 ^ b_d) & cin_d);
   assign v_d     = (I0[WIDTH-1] == b_d[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != I0[WIDTH-1]);
   assign res_d   = arith_d ? sum_d[WIDTH-1:0] : lg_d;
   assign dec_d   = (DEC_EN != 0) && D && (op[2:1] == 2'b00);

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_res_q   <= '0;
         s1_carry_q <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_co_q    <= 1'b0;
         s1_v_q     <= 1'b0;
         s1_ci_q    <= 1'b0;
         s1_dec_q   <= 1'b0;
         s1_sub_q   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_res_q   <= res_d;
            s1_carry_q <= arith_d ? carry_d : '0;
            s1_a_q     <= I0;
            s1_b_q     <= b_d;
            s1_co_q    <= arith_d & sum_d[WIDTH];
            s1_v_q     <= arith_d & v_d;
            s1_ci_q    <= CI;
            s1_dec_q   <= dec_d;
            s1_sub_q   <= sub_d;
         end
      end
   end

   // Nibble-serial BCD correction on the registered operands.
   always_comb begin
      dec_o = '0;
      dec_c = s1_ci_q;
      dec_s = '0;
      for (int k = 0; k < NIB; k++) begin
         dec_s = {1'b0, s1_a_q[4*k +: 4]} +
                 {1'b0, s1_b_q[4*k +: 4]} + {4'b0, dec_c};
         if (s1_sub_q) begin
            dec_c = dec_s[4];
            dec_o[4*k +: 4] = dec_c ? dec_s[3:0]
                                    : dec_s[3:0] - 4'd6;
         end else if (dec_s > 5'd9) begin
            dec_c = 1'b1;
            dec_o[4*k +: 4] = dec_s[3:0] + 4'd6;
         end else begin
            dec_c = 1'b0;
            dec_o[4*k +: 4] = dec_s[3:0];
         end
      end
   end

   assign o_d  = s1_dec_q ? dec_o : s1_res_q;
   assign co_d = s1_dec_q ? dec_c : s1_co_q;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         s2_valid_q <= 1'b0;
         o_q        <= '0;
         carry_q    <= '0;
         co_q       <= 1'b0;
         v_q        <= 1'b0;
         n_q        <= 1'b0;
         z_q        <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            o_q     <= o_d;
            carry_q <= s1_carry_q;
            co_q    <= co_d;
            v_q     <= s1_v_q;
            n_q     <= o_d[WIDTH-1];
            z_q     <= (o_d == '0);
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign O         = o_q;
   assign CO        = co_q;
   assign V         = v_q;
   assign N         = n_q;
   assign Z         = z_q;
   assign CARRY     = carry_q;
endmodule

// File: tb/tb_addn_dec.sv
// Bench for addn_dec: 8-bit decimal and 16-bit binary-only
// instances against an arithmetic reference model.
module tb_addn_dec;
   typedef struct packed {
      logic [31:0] o;
      logic        co, v, n, z;
      logic [31:0] carry;
   } res_t;

   logic        clk = 1'b0;
   logic        RST;
   logic        in_valid, out_ready;
   logic [7:0]  a8, b8;
   logic [2:0]  op8;
   logic        ci8, d8;
   logic [15:0] a16, b16;
   logic [2:0]  op16;
   logic        ci16, d16;
   logic        rdy8, ov8, co8, v8, n8, z8;
   logic [7:0]  o8, c8;
   logic        rdy16, ov16, co16, v16, n16, z16;
   logic [15:0] o16, c16;

   int   errors = 0;
   int   checks = 0;
   res_t q8[$];
   res_t q16[$];
   res_t r, r8, r16;
   logic        held;
   logic [19:0] hold_v;

   always #5 clk = ~clk;

   addn_dec #(.WIDTH(8), .DEC_EN(1)) u8 (
      .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(rdy8),
      .I0(a8), .I1(b8), .CI(ci8), .op(op8), .D(d8),
      .out_valid(ov8), .out_ready(out_ready), .O(o8), .CO(co8),
      .V(v8), .N(n8), .Z(z8), .CARRY(c8));

   addn_dec #(.WIDTH(16), .DEC_EN(0)) u16 (
      .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(rdy16),
      .I0(a16), .I1(b16), .CI(ci16), .op(op16), .D(d16),
      .out_valid(ov16), .out_ready(out_ready), .O(o16), .CO(co16),
      .V(v16), .N(n16), .Z(z16), .CARRY(c16));

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic longint bcd2int(longint x, int nd);
      longint v = 0;
      for (int i = nd - 1; i >= 0; i--)
         v = v * 10 + ((x >> (4 * i)) & 15);
      return v;
   endfunction

   function automatic longint int2bcd(longint x, int nd);
      longint v = 0;
      for (int i = 0; i < nd; i++) begin
         v = v | ((x % 10) << (4 * i));
         x = x / 10;
      end
      return v;
   endfunction

   function automatic res_t model(int w, bit de, longint a, longint b,
                                  bit ci, int op, bit d);
      res_t   m_r;
      longint m, half, bb, s, sa, sb, pm, p, dr;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      m_r  = '0;
      bb   = 0;
      if (op >= 2 && op <= 5) begin
         case (op)
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            default: s = a;
         endcase
         m_r.o = 32'(s);
      end else begin
         case (op)
            0: bb = b;
            1: bb = ~b & m;
            6: bb = 0;
            default: bb = m;
         endcase
         s = a + bb + longint'(ci);
         m_r.o  = 32'(s & m);
         m_r.co = ((s >> w) & 1) != 0;
         for (int i = 0; i < w; i++) begin
            pm = (longint'(1) << (i + 1)) - 1;
            m_r.carry[i] =
               (((a & pm) + (bb & pm) + longint'(ci)) >> (i + 1)) != 0;
         end
         sa = (a >= half) ? a - 2 * half : a;
         sb = (bb >= half) ? bb - 2 * half : bb;
         s  = sa + sb + longint'(ci);
         m_r.v = (s >= half) || (s < -half);
         if (de && d && op < 2) begin
            p = 1;
            for (int i = 0; i < w / 4; i++) p = p * 10;
            if (op == 0) begin
               dr = bcd2int(a, w / 4) + bcd2int(b, w / 4) + longint'(ci);
               m_r.co = dr >= p;
               if (dr >= p) dr = dr - p;
            end else begin
               dr = bcd2int(a, w / 4) - bcd2int(b, w / 4) - (ci ? 0 : 1);
               m_r.co = dr >= 0;
               if (dr < 0) dr = dr + p;
            end
            m_r.o = 32'(int2bcd(dr, w / 4));
         end
      end
      m_r.n = m_r.o[w-1];
      m_r.z = (m_r.o == 0);
      return m_r;
   endfunction

   function automatic longint gen(int w, bit bcd);
      longint v = 0;
      for (int i = 0; i < w / 4; i++)
         v = v | (longint'(bcd ? $urandom_range(0, 9)
                               : $urandom_range(0, 15)) << (4 * i));
      return v;
   endfunction

   always @(negedge clk or posedge RST) begin
      if (RST) begin
         q8.delete();
         q16.delete();
         held = 1'b0;
      end else begin
         if (held)
            chk("hold8", {ov8, o8, co8, v8, n8, z8, c8}, {1'b1, hold_v});
         held   = ov8 && !out_ready;
         hold_v = {o8, co8, v8, n8, z8, c8};
         if (in_valid && rdy8)
            q8.push_back(model(8, 1'b1, longint'(a8), longint'(b8),
                               ci8, int'(op8), d8));
         if (in_valid && rdy16)
            q16.push_back(model(16, 1'b0, longint'(a16), longint'(b16),
                                ci16, int'(op16), d16));
         if (ov8 && out_ready) begin
            chk("stray8", q8.size() != 0, 1);
            if (q8.size() != 0) begin
               r8 = q8.pop_front();
               chk("o8", o8, r8.o);
               chk("flags8", {co8, v8, n8, z8},
                   {r8.co, r8.v, r8.n, r8.z});
               chk("carry8", c8, r8.carry);
            end
         end
         if (ov16 && out_ready) begin
            chk("stray16", q16.size() != 0, 1);
            if (q16.size() != 0) begin
               r16 = q16.pop_front();
               chk("o16", o16, r16.o);
               chk("flags16", {co16, v16, n16, z16},
                   {r16.co, r16.v, r16.n, r16.z});
               chk("carry16", c16, r16.carry);
            end
         end
      end
   end

   task automatic offer(input logic [2:0] p8, input logic [7:0] x8,
                        input logic [7:0] y8, input logic cc8,
                        input logic dd8, input logic [2:0] p16,
                        input logic [15:0] x16, input logic [15:0] y16,
                        input logic cc16, input logic dd16);
      int n = 0;
      @(posedge clk); #1;
      op8 = p8; a8 = x8; b8 = y8; ci8 = cc8; d8 = dd8;
      op16 = p16; a16 = x16; b16 = y16; ci16 = cc16; d16 = dd16;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy8 && n < 50);
      if (!rdy8) chk("offer.timeout", rdy8, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a8 = '0; b8 = '0; op8 = '0; ci8 = 1'b0; d8 = 1'b0;
      a16 = '0; b16 = '0; op16 = '0; ci16 = 1'b0; d16 = 1'b0;
      #1;
      chk("rst.state", {ov8, rdy8, o8, co8, v8, n8, z8, c8},
          {2'b01, 20'h0});

      r = model(8, 1'b1, 'h7F, 'h01, 1'b0, 0, 1'b0);
      chk("pin.add", {r.o[7:0], r.co, r.v, r.n, r.z, r.carry[7:0]},
          {8'h80, 4'b0110, 8'h7F});
      r = model(8, 1'b1, 'h58, 'h46, 1'b1, 0, 1'b1);
      chk("pin.dadd", {r.o[7:0], r.co, r.z}, {8'h05, 2'b10});
      r = model(8, 1'b1, 'h12, 'h21, 1'b1, 1, 1'b1);
      chk("pin.dsub", {r.o[7:0], r.co, r.n}, {8'h91, 2'b01});
      r = model(8, 1'b0, 'h12, 'h21, 1'b1, 1, 1'b1);
      chk("pin.nodec", {r.o[7:0], r.co}, {8'hF1, 1'b0});
      r = model(16, 1'b0, 'h0, 'h1, 1'b1, 1, 1'b0);
      chk("pin.wsub", {r.o[15:0], r.co, r.v, r.n, r.z},
          {16'hFFFF, 4'b0010});

      repeat (2) @(posedge clk);
      #2 RST = 1'b0;

      offer(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0,
            3'd1, 16'h0000, 16'h0001, 1'b1, 1'b0);
      @(negedge clk); chk("lat.early", ov8, 0);
      @(negedge clk); chk("lat.due", ov8, 1);
      chk("add.lit", {o8, co8, v8, n8, z8, c8}, {8'h80, 4'b0110, 8'h7F});
      chk("wsub.lit", {o16, co16, v16, n16, z16}, {16'hFFFF, 4'b0010});

      offer(3'd0, 8'h58, 8'h46, 1'b1, 1'b1,
            3'd1, 16'h0012, 16'h0021, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      chk("dadd.lit", {ov8, o8, co8, z8}, {1'b1, 8'h05, 2'b10});
      chk("nodec.lit", {o16, co16}, {16'hFFF1, 1'b0});

      offer(3'd1, 8'h12, 8'h21, 1'b1, 1'b1,
            3'd2, 16'h00F0, 16'h0F0F, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("dsub.lit", {ov8, o8, co8, n8}, {1'b1, 8'h91, 2'b01});
      chk("and.lit", {o16, z16, co16}, {16'h0000, 2'b10});

      // Backpressure: two accepted, third stalls until drain.
      @(posedge clk); #1;
      out_ready = 1'b0; op8 = 3'd0; b8 = 8'h10; d8 = 1'b0;
      a8 = 8'h01; in_valid = 1'b1;
      @(negedge clk); chk("bp.rdy1", rdy8, 1);
      @(posedge clk); #1; a8 = 8'h02;
      @(negedge clk); chk("bp.rdy2", rdy8, 1);
      @(posedge clk); #1; a8 = 8'h03;
      repeat (3) begin
         @(negedge clk);
         chk("bp.stall", {rdy8, ov8}, 2'b01);
      end
      chk("bp.count", q8.size(), 2);
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk); chk("bp.rdy3", rdy8, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Reset with both stages full.
      @(posedge clk); #1;
      out_ready = 1'b0; a8 = 8'h44; in_valid = 1'b1;
      @(posedge clk); #1; a8 = 8'h55;
      @(posedge clk); #1; in_valid = 1'b0;
      chk("rst.full", {ov8, rdy8}, 2'b10);
      #1 RST = 1'b1;
      #1 chk("rst.async", {ov8, rdy8, ov16, rdy16, o8, co8, v8, n8, z8, c8},
             {4'b0101, 20'h0});
      #1 RST = 1'b0;
      out_ready = 1'b1;
      op8 = 3'd6; a8 = 8'hFF; ci8 = 1'b1; d8 = 1'b0;
      op16 = 3'd7; a16 = 16'h0000; ci16 = 1'b0; d16 = 1'b0;
      in_valid = 1'b1;
      @(negedge clk); chk("rst.first", {ov8, rdy8}, 2'b01);
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("inc.lit", {ov8, o8, co8, v8, n8, z8, c8},
          {1'b1, 8'h00, 4'b1001, 8'hFF});
      chk("dec.lit", {o16, co16}, {16'hFFFF, 1'b0});

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         op8  = 3'($urandom);
         d8   = 1'($urandom);
         ci8  = 1'($urandom);
         a8   = 8'(gen(8, d8));
         b8   = 8'(gen(8, d8));
         op16 = 3'($urandom);
         d16  = 1'($urandom);
         ci16 = 1'($urandom);
         a16  = 16'(gen(16, 1'b0));
         b16  = 16'(gen(16, 1'b0));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("drain8", q8.size(), 0);
      chk("drain16", q16.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
